// File: rtl/generic_countdown_timer.sv
// Loadable, prescaled down-counting timer with one-shot/periodic modes,
// pause/resume, abort and a registered terminal-count pulse.
module generic_countdown_timer #(
   parameter int WIDTH      = 5,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      load_val,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  periodic,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  pause,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSED = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                r_state;
   logic [WIDTH-1:0]      r_count;
   logic [WIDTH-1:0]      r_reload;
   logic [PRESCALE_W-1:0] r_pl;
   logic [PRESCALE_W-1:0] r_pc;
   logic                  r_mode;
   logic                  r_tc;
   logic                  r_err;

   always_ff @(posedge clk) begin
      r_tc  <= 1'b0;
      r_err <= 1'b0;
      if (rst) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_pl     <= '0;
         r_pc     <= '0;
         r_mode   <= 1'b0;
      end else if (stop) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_pc    <= '0;
      end else if (start) begin
         // A rejected start (zero load) still consumes the edge: nothing else advances.
         if (load_val != '0) begin
            r_state  <= S_RUN;
            r_count  <= load_val;
            r_reload <= load_val;
            r_pl     <= prescale;
            r_mode   <= periodic;
            r_pc     <= '0;
         end else begin
            r_err <= 1'b1;
         end
      end else begin
         case (r_state)
            S_RUN: begin
               if (pause) begin
                  r_state <= S_PAUSED;
               end else if (r_pc != r_pl) begin
                  r_pc <= r_pc + 1'b1;
               end else begin
                  r_pc <= '0;
                  if (r_count > WIDTH'(1)) begin
                     r_count <= r_count - 1'b1;
                  end else if (r_mode) begin
                     r_count <= r_reload;
                     r_tc    <= 1'b1;
                  end else begin
                     r_count <= '0;
                     r_tc    <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_PAUSED: begin
               if (!pause) r_state <= S_RUN;
            end
            default: ;
         endcase
      end
   end

   assign count = r_count;
   assign tc    = r_tc;
   assign err   = r_err;
   assign busy  = (r_state == S_RUN) || (r_state == S_PAUSED);
   assign done  = (r_state == S_DONE);

endmodule
